// File: rtl/sram_test_pkg.sv
// Shared types and helpers for the SRAM write/read-back test sequencer.
// The pattern mixes the low two address bytes with the latched seed.
package sram_test_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        GAP     = 3'd5,
        DONE    = 3'd6
    } state_t;

    function automatic logic [7:0] pat(input logic [15:0] a, input logic [7:0] seed);
        return a[7:0] ^ a[15:8] ^ seed;
    endfunction

endpackage

// File: rtl/sram_test_checker.sv
// Read-back comparator: counts mismatches (saturating) and remembers the
// address of the first one. Cleared at the start of every run.
module sram_test_checker
    import sram_test_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              check,
    input  logic [DATA_W-1:0] actual,
    input  logic [DATA_W-1:0] expected,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else if (check && (actual != expected)) begin
            if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (!first_err_valid) begin
                first_err_addr  <= addr;
                first_err_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_test_sequencer.sv
// Drives the SRAM controller request port: writes a seeded pattern over
// 0..LAST_ADDR, reads it back, and reports errors and timeouts.
//
// state   | meaning
// IDLE    | no run since reset; waiting for go
// WR_REQ  | waiting for busy low, then pulses a write request
// WR_WAIT | waiting for writing_finished_signal (timed)
// RD_REQ  | waiting for busy low, then pulses a read request
// RD_WAIT | waiting for data_ready_signal (timed), compares read data
// GAP     | one idle cycle between operations; advances the address
// DONE    | run complete; results held until go or reset
module sram_test_sequencer
    import sram_test_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
    parameter int                TIMEOUT   = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] seed,
    output logic              start_operation,
    output logic              rw,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_f2s,
    input  logic [DATA_W-1:0] data_s2f,
    input  logic              data_ready_signal,
    input  logic              writing_finished_signal,
    input  logic              busy_signal,
    output logic              active,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid,
    output logic              timeout_err
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] data_hold;
    logic [DATA_W-1:0] seed_q;
    logic [TO_W-1:0]   to_cnt;
    logic              rd_phase;
    logic              start_run;
    logic              issue;
    logic              to_expire;
    logic              req_st;
    logic              wait_st;
    logic              check;
    logic [15:0]       addr_lo;
    logic [DATA_W-1:0] pat_cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        issue     = 1'b0;
        to_expire = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (go) begin
                    start_run = 1'b1;
                    state_nxt = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!busy_signal) begin
                    issue     = 1'b1;
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (writing_finished_signal) begin
                    state_nxt = GAP;
                end else if (to_cnt == TO_LAST) begin
                    to_expire = 1'b1;
                    state_nxt = DONE;
                end
            end
            RD_REQ: begin
                if (!busy_signal) begin
                    issue     = 1'b1;
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (data_ready_signal) begin
                    state_nxt = GAP;
                end else if (to_cnt == TO_LAST) begin
                    to_expire = 1'b1;
                    state_nxt = DONE;
                end
            end
            GAP: begin
                if (addr_cnt == LAST_ADDR) begin
                    state_nxt = rd_phase ? DONE : RD_REQ;
                end else begin
                    state_nxt = rd_phase ? RD_REQ : WR_REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_st  = (state == WR_REQ) || (state == RD_REQ);
        wait_st = (state == WR_WAIT) || (state == RD_WAIT);
        addr_lo = 16'(addr_cnt);
        pat_cur = DATA_W'(pat(addr_lo, 8'(seed_q)));
        check   = (state == RD_WAIT) && data_ready_signal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt    <= '0;
            addr_hold   <= '0;
            data_hold   <= '0;
            seed_q      <= '0;
            to_cnt      <= '0;
            rd_phase    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            addr_hold <= address;
            data_hold <= data_f2s;
            if (start_run) begin
                seed_q      <= seed;
                addr_cnt    <= '0;
                rd_phase    <= 1'b0;
                timeout_err <= 1'b0;
                to_cnt      <= '0;
            end else if (issue) begin
                to_cnt <= '0;
            end else if (wait_st) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_expire) begin
                timeout_err <= 1'b1;
            end
            // The address only moves in GAP; it stays on LAST_ADDR after the final read.
            if (state == GAP) begin
                if (addr_cnt == LAST_ADDR) begin
                    if (!rd_phase) begin
                        addr_cnt <= '0;
                        rd_phase <= 1'b1;
                    end
                end else begin
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end
        end
    end

    // Request fields track the counter only in *_REQ and are frozen otherwise.
    always_comb begin
        start_operation = req_st && !busy_signal;
        rw              = (state == RD_REQ);
        address         = req_st ? addr_cnt : addr_hold;
        data_f2s        = req_st ? pat_cur : data_hold;
        active          = (state != IDLE) && (state != DONE);
        done            = (state == DONE);
        pass            = done && (err_count == 16'd0) && !timeout_err;
    end

    sram_test_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk             (clk),
        .reset           (reset),
        .clear           (start_run),
        .check           (check),
        .actual          (data_s2f),
        .expected        (pat_cur),
        .addr            (addr_cnt),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr),
        .first_err_valid (first_err_valid)
    );

endmodule
